// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Shares the register file's single write port between the ALU writeback and
// the memory load return. Round-robin arbitration on valid/ready handshakes,
// a registered write stage that drives the register file directly, and a
// pending-write scoreboard that decode uses to stall on hazards.
module reg_write_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic                    clk,
   input  logic                    reset,

   // ALU writeback producer
   input  logic                    alu_valid,
   input  logic [ADDR_W-1:0]       alu_addr,
   input  logic [DATA_W-1:0]       alu_data,
   output logic                    alu_ready,

   // Load return producer
   input  logic                    mem_valid,
   input  logic [ADDR_W-1:0]       mem_addr,
   input  logic [DATA_W-1:0]       mem_data,
   output logic                    mem_ready,

   // Decode reservation of a destination register
   input  logic                    reserve_en,
   input  logic [ADDR_W-1:0]       reserve_addr,

   // Register file write port
   output logic                    rf_write_enable,
   output logic [ADDR_W-1:0]       rf_write_addr,
   output logic [DATA_W-1:0]       rf_write_data,

   // Scoreboard status
   output logic [(2**ADDR_W)-1:0]  busy,
   output logic                    orphan_err
);

   localparam int NUM_REGS = 2**ADDR_W;
   localparam logic [NUM_REGS-1:0] ONE_HOT_BASE = {{(NUM_REGS-1){1'b0}}, 1'b1};

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_MEM = 1'b1
   } grant_e;

   grant_e              last_grant;
   logic                alu_win;
   logic                mem_win;
   logic                transfer;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_data;
   logic [NUM_REGS-1:0] commit_mask;
   logic [NUM_REGS-1:0] reserve_mask;
   logic [NUM_REGS-1:0] busy_next;
   logic                orphan_hit;

   // Grant decision: a lone requester always wins; a tie goes to the
   // requester that did not win the previous transfer.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      alu_win = 1'b0;
      mem_win = 1'b0;
      if (alu_valid && mem_valid) begin
         if (last_grant == GRANT_MEM) begin
            alu_win = 1'b1;
         end else begin
            mem_win = 1'b1;
         end
      end else if (alu_valid) begin
         alu_win = 1'b1;
      end else if (mem_valid) begin
         mem_win = 1'b1;
      end
   end

   // Ready depends only on the valids and last_grant, never on reserve_*.
   assign alu_ready = alu_win;
   assign mem_ready = mem_win;
   assign transfer  = alu_win | mem_win;

   // Steer the winning producer's address and data toward the write stage.
   always_comb begin
      win_addr = alu_addr;
      win_data = alu_data;
      if (mem_win) begin
         win_addr = mem_addr;
         win_data = mem_data;
      end
   end

   // Round-robin pointer: moves only when a transfer actually happens.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (reset) begin
         last_grant <= GRANT_MEM;
      end else if (alu_win) begin
         last_grant <= GRANT_ALU;
      end else if (mem_win) begin
         last_grant <= GRANT_MEM;
      end
   end

   // Registered write stage: one enable pulse per accepted transfer; the
   // address and data hold their last value while idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_write_enable <= 1'b0;
         rf_write_addr   <= '0;
         rf_write_data   <= '0;
      end else begin
         rf_write_enable <= transfer;
         if (transfer) begin
            rf_write_addr <= win_addr;
            rf_write_data <= win_data;
         end
      end
   end

   // Scoreboard next state: commit clears, reservation sets, and the set is
   // applied last so a same-cycle reserve and commit leave the bit busy.
   always_comb begin
      commit_mask  = '0;
      reserve_mask = '0;
      if (rf_write_enable) begin
         commit_mask = ONE_HOT_BASE << rf_write_addr;
      end
      if (reserve_en) begin
         reserve_mask = ONE_HOT_BASE << reserve_addr;
      end
      busy_next  = (busy & ~commit_mask) | reserve_mask;
      orphan_hit = rf_write_enable && !busy[rf_write_addr];
   end

   // Pending-write flags and the sticky orphan-commit flag.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: busy is a small flop vector, not a RAM, so it is cleared by
      // reset like any other control state; stale flags would stall decode.
      if (reset) begin
         busy       <= '0;
         orphan_err <= 1'b0;
      end else begin
         busy <= busy_next;
         if (orphan_hit) begin
            orphan_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
// Table-driven vectors give the stimulus and hand-derived ready values for
// each cycle; accepted writes go into a scoreboard queue and are popped when
// the register file write stage fires. Busy/orphan come from a small model.
module tb_reg_write_arbiter;

   logic       clk;
   logic       reset;
   logic       alu_valid;
   logic [2:0] alu_addr;
   logic [7:0] alu_data;
   logic       alu_ready;
   logic       mem_valid;
   logic [2:0] mem_addr;
   logic [7:0] mem_data;
   logic       mem_ready;
   logic       reserve_en;
   logic [2:0] reserve_addr;
   logic       rf_write_enable;
   logic [2:0] rf_write_addr;
   logic [7:0] rf_write_data;
   logic [7:0] busy;
   logic       orphan_err;

   reg_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk             (clk),
      .reset           (reset),
      .alu_valid       (alu_valid),
      .alu_addr        (alu_addr),
      .alu_data        (alu_data),
      .alu_ready       (alu_ready),
      .mem_valid       (mem_valid),
      .mem_addr        (mem_addr),
      .mem_data        (mem_data),
      .mem_ready       (mem_ready),
      .reserve_en      (reserve_en),
      .reserve_addr    (reserve_addr),
      .rf_write_enable (rf_write_enable),
      .rf_write_addr   (rf_write_addr),
      .rf_write_data   (rf_write_data),
      .busy            (busy),
      .orphan_err      (orphan_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       av;
      logic [2:0] aa;
      logic [7:0] ad;
      logic       mv;
      logic [2:0] ma;
      logic [7:0] md;
      logic       re;
      logic [2:0] ra;
      logic       exp_ar;
      logic       exp_mr;
   } vec_t;

   typedef struct packed {
      logic [2:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t        exp_q[$];
   int         n_checks;
   int         n_errors;

   // Reference model state
   logic [7:0] m_busy;
   logic       m_orphan;
   logic       m_we;
   logic [2:0] m_wa;

   vec_t       tbl[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                               input logic mv, input logic [2:0] ma, input logic [7:0] md,
                               input logic re, input logic [2:0] ra,
                               input logic exp_ar, input logic exp_mr);
      vec_t v;
      v.av = av; v.aa = aa; v.ad = ad;
      v.mv = mv; v.ma = ma; v.md = md;
      v.re = re; v.ra = ra;
      v.exp_ar = exp_ar; v.exp_mr = exp_mr;
      return v;
   endfunction

   // One cycle: called at posedge+1, drives inputs, checks ready at negedge,
   // then checks the write stage and scoreboard just after the next posedge.
   task automatic apply(input vec_t v);
      wr_t        w;
      logic [7:0] nb;
      alu_valid    = v.av;
      alu_addr     = v.aa;
      alu_data     = v.ad;
      mem_valid    = v.mv;
      mem_addr     = v.ma;
      mem_data     = v.md;
      reserve_en   = v.re;
      reserve_addr = v.ra;
      @(negedge clk);
      check("alu_ready", alu_ready, v.exp_ar);
      check("mem_ready", mem_ready, v.exp_mr);
      if (v.exp_ar) exp_q.push_back({v.aa, v.ad});
      if (v.exp_mr) exp_q.push_back({v.ma, v.md});
      nb = m_busy;
      if (m_we) begin
         if (!m_busy[m_wa]) m_orphan = 1'b1;
         nb[m_wa] = 1'b0;
      end
      if (v.re) nb[v.ra] = 1'b1;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         w    = exp_q.pop_front();
         m_we = 1'b1;
         m_wa = w.a;
         check("rf_write_enable", rf_write_enable, 1);
         check("rf_write_addr", rf_write_addr, w.a);
         check("rf_write_data", rf_write_data, w.d);
      end else begin
         m_we = 1'b0;
         check("rf_write_enable", rf_write_enable, 0);
      end
      m_busy = nb;
      check("busy", busy, m_busy);
      check("orphan_err", orphan_err, m_orphan);
   endtask

   task automatic model_reset();
      m_busy   = '0;
      m_orphan = 1'b0;
      m_we     = 1'b0;
      m_wa     = '0;
      exp_q.delete();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_we"},       rf_write_enable, 0);
      check({tag, "_addr"},     rf_write_addr,   0);
      check({tag, "_data"},     rf_write_data,   0);
      check({tag, "_busy"},     busy,            0);
      check({tag, "_orphan"},   orphan_err,      0);
      check({tag, "_alu_rdy"},  alu_ready,       0);
      check({tag, "_mem_rdy"},  mem_ready,       0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      model_reset();

      //         av aa ad     mv ma md     re ra  ar mr
      tbl[0]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 5, 0, 0); // reserve r5
      tbl[1]  = mk(1, 5, 8'hA3, 0, 0, 8'h00, 0, 0, 1, 0); // single ALU write
      tbl[2]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 3, 0, 0); // reserve r3
      tbl[3]  = mk(1, 3, 8'h44, 0, 0, 8'h00, 0, 0, 1, 0); // ALU write r3
      tbl[4]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 3, 0, 0); // commit r3 + reserve r3
      tbl[5]  = mk(0, 0, 8'h00, 0, 0, 8'h00, 1, 3, 0, 0); // reserve already-busy r3
      tbl[6]  = mk(1, 3, 8'h45, 0, 0, 8'h00, 0, 0, 1, 0); // one commit clears r3
      tbl[7]  = mk(0, 0, 8'h00, 1, 1, 8'h11, 0, 0, 0, 1); // MEM alone
      tbl[8]  = mk(1, 4, 8'h20, 1, 2, 8'h30, 0, 0, 1, 0); // tie: ALU
      tbl[9]  = mk(1, 5, 8'h21, 1, 2, 8'h30, 0, 0, 0, 1); // tie: MEM, r2 data held
      tbl[10] = mk(1, 5, 8'h21, 1, 6, 8'h31, 0, 0, 1, 0); // tie: ALU
      tbl[11] = mk(1, 1, 8'h22, 1, 6, 8'h31, 0, 0, 0, 1); // tie: MEM
      tbl[12] = mk(1, 1, 8'h22, 1, 3, 8'h32, 0, 0, 1, 0); // tie: ALU
      tbl[13] = mk(1, 0, 8'h23, 1, 3, 8'h32, 0, 0, 0, 1); // tie: MEM
      tbl[14] = mk(1, 0, 8'h23, 0, 0, 8'h00, 0, 0, 1, 0); // ALU alone
      tbl[15] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);
      tbl[16] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0);

      reset        = 1'b0;
      alu_valid    = 1'b0;
      alu_addr     = '0;
      alu_data     = '0;
      mem_valid    = 1'b0;
      mem_addr     = '0;
      mem_data     = '0;
      reserve_en   = 1'b0;
      reserve_addr = '0;
      #1 reset = 1'b1;
      #1 check_reset_state("por");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         apply(tbl[i]);
      end

      // Reset mid-cycle while a write is in flight: outputs clear at once
      // and the dropped write never appears at the following edge.
      apply(mk(1, 2, 8'h55, 0, 0, 8'h00, 1, 4, 1, 0));
      alu_valid  = 1'b0;
      reserve_en = 1'b0;
      #1 reset = 1'b1;
      #1 check_reset_state("midrst");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_no_write", rf_write_enable, 0);
      check("midrst_busy_after", busy, 0);

      // Orphan commit to r7; the tie also confirms last_grant restarts at MEM.
      apply(mk(1, 7, 8'h77, 1, 6, 8'h66, 0, 0, 1, 0));
      apply(mk(0, 0, 8'h00, 1, 6, 8'h66, 0, 0, 0, 1));
      apply(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
      apply(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
      apply(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
      check("orphan_sticky", orphan_err, 1);

      #1 reset = 1'b1;
      #1 check("orphan_cleared", orphan_err, 0);
      check("final_busy", busy, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Write-port arbiter and scoreboard for the 8-entry x 8-bit register file. It shares the register file's single write port between two producers, the ALU writeback and the memory load return, using round-robin arbitration and valid/ready handshakes. It registers the winning write into the register file's write_enable, destination and data_in inputs. A pending-write scoreboard tracks which registers have an issued but uncommitted producer, so decode can stall on hazards.

## Interface
- DATA_W, 8, register data width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- alu_valid  input  1  ALU has a write pending
- alu_addr  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- alu_ready  output  1  ALU write accepted this cycle
- mem_valid  input  1  load unit has a write pending
- mem_addr  input  ADDR_W  load destination register
- mem_data  input  DATA_W  load data
- mem_ready  output  1  load write accepted this cycle
- reserve_en  input  1  decode issues an instruction that will write reserve_addr
- reserve_addr  input  ADDR_W  register being reserved
- rf_write_enable  output  1  to register file write_enable
- rf_write_addr  output  ADDR_W  to register file write destination
- rf_write_data  output  DATA_W  to register file data_in
- busy  output  2**ADDR_W  bit i high: register i has an uncommitted pending write
- orphan_err  output  1  sticky: a commit hit a register that was not busy

## Operation
- Handshake: a producer holds valid, addr and data stable until it sees ready. Ready is combinational, asserts only while that producer's valid is high, and asserts for at most one producer per cycle. A transfer occurs on a clock edge where valid && ready.
- Arbitration: one requester valid -> it is granted. Both valid -> grant goes to the requester not granted last; the last_grant pointer updates only on a transfer. After reset, last_grant = MEM, so the ALU wins the first tie.
- Output stage: the accepted addr/data is registered. rf_write_enable is high for exactly one cycle per transfer. No backpressure from the register file, so there are no bubbles and every cycle can carry a transfer.
- Scoreboard: reserve_en sets busy[reserve_addr] at the edge. A commit (rf_write_enable high) clears busy[rf_write_addr] at the edge where the register file captures the data.
- Same-cycle reserve and commit to the same register: set wins, and busy stays 1.
- Reserve to an already-busy register: busy stays 1. It is not counted, so a single commit clears it.
- Commit to a non-busy register: the write still goes through, and orphan_err sets and holds until reset.
- Reset mid-operation: the in-flight output-stage write is dropped (rf_write_enable forced 0), busy clears, and producers must re-present.

## Timing
- Reset values: rf_write_enable=0, rf_write_addr=0, rf_write_data=0, busy=0, orphan_err=0, alu_ready=0 and mem_ready=0 (because the valids are low), last_grant=MEM.
- Latency: a transfer at edge N gives rf_write_enable high during cycle N..N+1, and the register file writes at edge N+1.
- busy[i] drops at edge N+1 for a transfer at edge N to register i.
- Throughput: 1 write per cycle. Under continuous dual valid, the grants strictly alternate ALU, MEM, ALU, ...
- Ready depends only on the current-cycle valids and the last_grant register. There is no path from reserve_* to ready.

## Test plan
- Reset: assert reset asynchronously mid-cycle with rf_write_enable=1 -> all outputs go to their reset values immediately, with no write at the next edge.
- Single ALU write: reserve_en r5, then alu_valid addr=5 data=0xA3 -> alu_ready in the same cycle, rf_write_enable/addr=5/data=0xA3 the next cycle, and busy[5] goes 1->0 at that commit edge.
- Tie fairness: alu_valid and mem_valid held high for 6 cycles with distinct data -> grants go ALU, MEM, ALU, MEM, ALU, MEM. There are 6 consecutive rf_write_enable pulses with matching data, and the ready signals are never both high.
- Hold stability: mem_valid high with mem_addr=2 while the ALU wins first -> mem_ready is 0 for that cycle and 1 the next, and register 2 is written with the unchanged mem_data.
- Scoreboard collision: busy[3]=1, with a commit to r3 and reserve_en r3 in the same cycle -> busy[3] remains 1 and orphan_err stays 0.
- Orphan: commit to r7 with busy[7]=0 -> the write happens, and orphan_err goes to 1 and stays there until reset.
